// File: rtl/imem_wait_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : imem_wait_responder_if
//  Description : imem fetch bus plus backdoor load port between the core
//                fetch stage (master) and the instruction-memory responder
//                (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface imem_wait_responder_if #(
    parameter int DW  = 16,
    parameter int AW  = 16,
    parameter int LAW = 10
);
    logic [AW-1:0]  PC;
    logic           instrmem_rd;
    logic           imem_busy;
    logic [DW-1:0]  Instr_dout;
    logic           complete_instr;
    logic           addr_err;
    logic           load_en;
    logic [LAW-1:0] load_addr;
    logic [DW-1:0]  load_data;

    modport master (
        output PC, instrmem_rd, load_en, load_addr, load_data,
        input  imem_busy, Instr_dout, complete_instr, addr_err
    );

    modport slave (
        input  PC, instrmem_rd, load_en, load_addr, load_data,
        output imem_busy, Instr_dout, complete_instr, addr_err
    );
endinterface
`default_nettype wire

// File: rtl/imem_wait_responder.sv
`default_nettype none
// ============================================================================
//  Module      : imem_wait_responder
//  Description : Loadable instruction memory answering PC fetches after a
//                configurable number of wait states, in blocking (one fetch
//                in flight) or pipelined (one fetch per cycle) mode.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_wait_responder #(
    parameter int            DW        = 16,
    parameter int            AW        = 16,
    parameter int            DEPTH     = 1024,
    parameter int            LATENCY   = 2,
    parameter int            PIPELINED = 0,
    parameter logic [DW-1:0] ERR_INSTR = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    imem_wait_responder_if.slave  bus
);
    localparam int          c_LAW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          c_SHIFT = $clog2(DW / 8);
    localparam logic [31:0] c_DEPTH = 32'(DEPTH);

    logic [DW-1:0] mem [DEPTH];

    logic [AW-1:0] w_idx;
    logic          w_err;
    logic [DW-1:0] w_rdata;
    logic          w_busy;
    logic          w_accept;
    logic          w_out_load;
    logic [DW-1:0] w_out_data;
    logic          w_out_err;

    logic          r_out_vld;
    logic [DW-1:0] r_out_data;
    logic          r_out_err;

    // Byte PC to word index; anything past the array is an error, never wrapped.
    assign w_idx    = bus.PC >> c_SHIFT;
    assign w_err    = (32'(w_idx) >= c_DEPTH);
    assign w_rdata  = w_err ? ERR_INSTR : mem[w_idx[c_LAW-1:0]];
    assign w_accept = bus.instrmem_rd && !w_busy;

    // Backdoor load; a fetch at the same edge sees the old word.
    always_ff @(posedge clock) begin
        if (bus.load_en && (32'(bus.load_addr) < c_DEPTH)) begin
            mem[bus.load_addr] <= bus.load_data;
        end
    end

    // Response register: pulses valid, holds data/err between responses.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_out_vld  <= 1'b0;
            r_out_data <= '0;
            r_out_err  <= 1'b0;
        end else begin
            r_out_vld <= w_out_load;
            if (w_out_load) begin
                r_out_data <= w_out_data;
                r_out_err  <= w_out_err;
            end
        end
    end

    assign bus.complete_instr = r_out_vld;
    assign bus.Instr_dout     = r_out_data;
    assign bus.addr_err       = r_out_err;
    assign bus.imem_busy      = w_busy;

    if (PIPELINED == 0) begin : g_blocking
        typedef enum logic [1:0] {
            S_IDLE = 2'd0,
            S_WAIT = 2'd1,
            S_RESP = 2'd2
        } state_t;

        state_t        r_state;
        state_t        w_state_nxt;
        logic [3:0]    r_cnt;
        logic [3:0]    w_cnt_nxt;
        logic [DW-1:0] r_hold_data;
        logic          r_hold_err;

        // State, wait counter and the word captured at accept.
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                r_state     <= S_IDLE;
                r_cnt       <= 4'd0;
                r_hold_data <= '0;
                r_hold_err  <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                if (w_accept) begin
                    r_hold_data <= w_rdata;
                    r_hold_err  <= w_err;
                end
            end
        end

        // IDLE/RESP accept a fetch; WAIT counts down until the response cycle.
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            case (r_state)
                S_WAIT: begin
                    if (r_cnt <= 4'd1) begin
                        w_state_nxt = S_RESP;
                    end else begin
                        w_cnt_nxt = r_cnt - 4'd1;
                    end
                end
                default: begin
                    if (w_accept) begin
                        w_cnt_nxt   = 4'(LATENCY - 1);
                        w_state_nxt = (LATENCY == 1) ? S_RESP : S_WAIT;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            endcase
        end

        assign w_busy     = (r_state == S_WAIT);
        assign w_out_load = (w_state_nxt == S_RESP);
        // With LATENCY=1 the response word comes straight from the array.
        assign w_out_data = (r_state == S_WAIT) ? r_hold_data : w_rdata;
        assign w_out_err  = (r_state == S_WAIT) ? r_hold_err  : w_err;
    end else begin : g_pipelined
        assign w_busy = 1'b0;

        if (LATENCY == 1) begin : g_lat1
            assign w_out_load = w_accept;
            assign w_out_data = w_rdata;
            assign w_out_err  = w_err;
        end else begin : g_latn
            logic [LATENCY-2:0] r_pv;
            logic [LATENCY-2:0] r_pe;
            logic [DW-1:0]      r_pd [LATENCY-1];

            // Valid bits of the delay line; cleared so nothing survives reset.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    r_pv <= '0;
                end else begin
                    r_pv[0] <= w_accept;
                    for (int j = 1; j < LATENCY - 1; j++) begin
                        r_pv[j] <= r_pv[j-1];
                    end
                end
            end

            // Payload of the delay line, qualified by the valid bits.
            always_ff @(posedge clock) begin
                r_pd[0] <= w_rdata;
                r_pe[0] <= w_err;
                for (int j = 1; j < LATENCY - 1; j++) begin
                    r_pd[j] <= r_pd[j-1];
                    r_pe[j] <= r_pe[j-1];
                end
            end

            assign w_out_load = r_pv[LATENCY-2];
            assign w_out_data = r_pd[LATENCY-2];
            assign w_out_err  = r_pe[LATENCY-2];
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_imem_wait_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_wait_responder
//  Description : Four responders (blocking L2, pipelined L3, blocking L4,
//                blocking L1) driven from one sequence and compared against
//                a response-queue model of the fetch/response rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_wait_responder;
    localparam int          N   = 4;
    localparam logic [15:0] ERR = 16'hDEAD;

    function automatic int lat_of(input int i);
        case (i)
            0:       return 2;
            1:       return 3;
            2:       return 4;
            default: return 1;
        endcase
    endfunction

    function automatic int pipe_of(input int i);
        return (i == 1) ? 1 : 0;
    endfunction

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] pc   [N];
    logic        rd   [N];
    logic        load_en;
    logic [9:0]  load_addr;
    logic [15:0] load_data;
    logic        busy_o [N];
    logic [15:0] dout_o [N];
    logic        cmpl_o [N];
    logic        err_o  [N];

    always #5 clock = ~clock;

    for (genvar g = 0; g < N; g++) begin : g_dut
        imem_wait_responder_if #(.DW(16), .AW(16), .LAW(10)) bus ();
        assign bus.PC          = pc[g];
        assign bus.instrmem_rd = rd[g];
        assign bus.load_en     = load_en;
        assign bus.load_addr   = load_addr;
        assign bus.load_data   = load_data;
        assign busy_o[g]       = bus.imem_busy;
        assign dout_o[g]       = bus.Instr_dout;
        assign cmpl_o[g]       = bus.complete_instr;
        assign err_o[g]        = bus.addr_err;

        imem_wait_responder #(
            .DW(16), .AW(16), .DEPTH(1024),
            .LATENCY(lat_of(g)), .PIPELINED(pipe_of(g)), .ERR_INSTR(ERR)
        ) dut (
            .clock (clock),
            .reset (reset),
            .bus   (bus)
        );
    end

    typedef struct {
        int          inst;
        int          due;
        logic [15:0] data;
        logic        err;
    } resp_t;

    resp_t       q [$];
    logic [15:0] mem_m [1024];
    int          last_due [N];
    logic [15:0] hold_d [N];
    logic        hold_e [N];
    int          edge_n;
    int          n_cmp;
    int          n_bad;

    task automatic chk(input string tag, input int i, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s inst%0d: observed %h expected %h", tag, i, obs, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        for (int i = 0; i < N; i++) begin
            last_due[i] = -1;
            hold_d[i]   = '0;
            hold_e[i]   = 1'b0;
        end
    endtask

    // One clock: model the coming edge, then check all instances after it.
    task automatic cycle();
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                if (rd[i] && (pipe_of(i) == 1 || edge_n > last_due[i])) begin
                    int    idx;
                    resp_t r;
                    idx    = int'(pc[i]) >> 1;
                    r.inst = i;
                    r.due  = edge_n + lat_of(i) - 1;
                    r.err  = (idx >= 1024);
                    r.data = r.err ? ERR : mem_m[idx];
                    q.push_back(r);
                    last_due[i] = r.due;
                end
            end
        end
        if (load_en) mem_m[load_addr] = load_data;
        @(posedge clock);
        #1;
        for (int i = 0; i < N; i++) begin
            int   found;
            logic exp_c;
            found = -1;
            exp_c = 1'b0;
            for (int k = 0; k < q.size(); k++) begin
                if (q[k].inst == i) begin
                    found = k;
                    break;
                end
            end
            if (found >= 0 && q[found].due == edge_n) begin
                exp_c     = 1'b1;
                hold_d[i] = q[found].data;
                hold_e[i] = q[found].err;
                q.delete(found);
            end
            chk("complete", i, 16'(cmpl_o[i]), 16'(exp_c));
            chk("dout",     i, dout_o[i], hold_d[i]);
            chk("addr_err", i, 16'(err_o[i]), 16'(hold_e[i]));
            chk("busy",     i, 16'(busy_o[i]), 16'(pipe_of(i) == 0 && edge_n < last_due[i]));
        end
        edge_n++;
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) cycle();
    endtask

    task automatic apply_reset();
        reset   = 1'b0;
        load_en = 1'b0;
        for (int i = 0; i < N; i++) rd[i] = 1'b0;
        model_clear();
        #1;
        for (int i = 0; i < N; i++) begin
            chk("rst_complete", i, 16'(cmpl_o[i]), 16'd0);
            chk("rst_dout",     i, dout_o[i], 16'd0);
            chk("rst_err",      i, 16'(err_o[i]), 16'd0);
            chk("rst_busy",     i, 16'(busy_o[i]), 16'd0);
        end
        cycle();
        reset = 1'b1;
    endtask

    task automatic load(input int a, input logic [15:0] d);
        load_en   = 1'b1;
        load_addr = 10'(a);
        load_data = d;
        cycle();
        load_en   = 1'b0;
    endtask

    task automatic fetch(input int i, input logic [15:0] p);
        rd[i] = 1'b1;
        pc[i] = p;
        cycle();
        rd[i] = 1'b0;
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        edge_n    = 0;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;
        for (int i = 0; i < N; i++) begin
            rd[i] = 1'b0;
            pc[i] = '0;
        end
        model_clear();
        @(negedge clock);
        apply_reset();

        // Fill the whole array so every fetch has a known expected word.
        for (int a = 0; a < 1024; a++) load(a, 16'($urandom));

        // Blocking L2 fetch of word 3.
        load(3, 16'hA5C3);
        fetch(0, 16'h0006);
        idle(3);

        // Pipelined L3, four back-to-back fetches.
        load(0, 16'h0011);
        load(1, 16'h0022);
        load(2, 16'h0033);
        load(3, 16'h0044);
        for (int k = 0; k < 4; k++) begin
            rd[1] = 1'b1;
            pc[1] = 16'(2 * k);
            cycle();
        end
        rd[1] = 1'b0;
        idle(5);

        // Out-of-range fetches: first index past the end and the very top.
        fetch(0, 16'h0800);
        idle(3);
        fetch(1, 16'hFFFE);
        idle(4);

        // Same-edge load and fetch of word 5 returns the old word.
        load(5, 16'h1234);
        load_en   = 1'b1;
        load_addr = 10'd5;
        load_data = 16'hBEEF;
        rd[0]     = 1'b1;
        pc[0]     = 16'd10;
        cycle();
        load_en   = 1'b0;
        rd[0]     = 1'b0;
        idle(3);
        fetch(0, 16'd10);
        idle(3);

        // Reset in the middle of a blocking L4 wait, then refetch at once.
        fetch(2, 16'h0020);
        cycle();
        apply_reset();
        fetch(2, 16'h0022);
        idle(5);

        // Blocking L1 with the request held for three fetches.
        rd[3] = 1'b1;
        pc[3] = 16'h0000;
        cycle();
        pc[3] = 16'h0002;
        cycle();
        pc[3] = 16'h0004;
        cycle();
        rd[3] = 1'b0;
        idle(2);

        // Random traffic on all instances with loads and one mid-run reset.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                rd[i] = ($urandom_range(0, 3) != 0);
                pc[i] = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(16'h0800, 16'hFFFF))
                                                    : 16'($urandom_range(0, 16'h07FF));
            end
            load_en   = ($urandom_range(0, 3) == 0);
            load_addr = 10'($urandom);
            load_data = 16'($urandom);
            if (c == 1500) apply_reset();
            else           cycle();
        end
        for (int i = 0; i < N; i++) rd[i] = 1'b0;
        load_en = 1'b0;
        idle(20);
        chk("drain", 0, 16'(q.size()), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
